// File: rtl/timer_pkg.sv
// Shared constants and helpers for the BCD timer path.
package timer_pkg;
  localparam int         DIGIT_W  = 4;
  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [15:0] MMSS_MAX = 16'h5959;

  // Limit a loaded digit to its per-position maximum (also catches 4'hA..F).
  function automatic logic [3:0] bcd_clamp(input logic [3:0] d, input logic [3:0] max);
    return (d > max) ? max : d;
  endfunction
endpackage

// File: rtl/bcd_digit_dn.sv
// One BCD down-counting digit with load clamp and underflow to MAX.
module bcd_digit_dn
  import timer_pkg::*;
#(
  parameter logic [3:0] MAX = BCD_MAX
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       ld,
  input  logic [3:0] ld_val,
  input  logic       dec,
  output logic [3:0] q,
  output logic       is_zero
);
  logic [3:0] r_q;

  // Digit register: clear > load > decrement > hold.
  always_ff @(posedge clk) begin
    if (clr)      r_q <= '0;
    else if (ld)  r_q <= bcd_clamp(ld_val, MAX);
    else if (dec) r_q <= (r_q == 4'd0) ? MAX : r_q - 4'd1;
  end

  assign q       = r_q;
  assign is_zero = (r_q == 4'd0);
endmodule

// File: rtl/bcd_down_timer.sv
// Multi-digit BCD down timer: borrow-chained digits, hold/wrap at zero, done pulse.
module bcd_down_timer
  import timer_pkg::*;
#(
  parameter int                            NDIGITS      = 4,
  parameter logic [DIGIT_W*NDIGITS-1:0]    DIGIT_MAX    = MMSS_MAX,
  parameter bit                            STOP_AT_ZERO = 1'b1
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic [DIGIT_W*NDIGITS-1:0] data,
  input  logic                       loadn,
  input  logic                       en,
  output logic [DIGIT_W*NDIGITS-1:0] count,
  output logic                       tc,
  output logic                       zero,
  output logic                       done
);
  localparam logic [DIGIT_W*NDIGITS-1:0] ONE = {{(DIGIT_W*NDIGITS-1){1'b0}}, 1'b1};

  logic [NDIGITS-1:0][DIGIT_W-1:0] w_q;
  logic [NDIGITS-1:0]              w_dig_zero;
  logic [NDIGITS-1:0]              w_borrow;
  logic [NDIGITS-1:0]              w_dec;
  logic                            w_hold;
  logic                            r_done;

  // In stop mode an all-zero count must not wrap, so every digit is frozen.
  assign w_hold = STOP_AT_ZERO && zero;

  genvar i;
  generate
    for (i = 0; i < NDIGITS; i++) begin : g_dig
      if (DIGIT_MAX[DIGIT_W*i +: DIGIT_W] > BCD_MAX ||
          DIGIT_MAX[DIGIT_W*i +: DIGIT_W] == 4'd0) begin : g_bad
        $error("bcd_down_timer: DIGIT_MAX digit %0d out of range 1..9", i);
      end

      // Digit i borrows only when every lower digit is zero.
      if (i == 0) begin : g_b0
        assign w_borrow[i] = 1'b1;
      end else begin : g_bn
        assign w_borrow[i] = w_borrow[i-1] & w_dig_zero[i-1];
      end

      assign w_dec[i] = en && !w_hold && w_borrow[i];

      bcd_digit_dn #(.MAX(DIGIT_MAX[DIGIT_W*i +: DIGIT_W])) u_dig (
        .clk     (clk),
        .clr     (clr),
        .ld      (!loadn),
        .ld_val  (data[DIGIT_W*i +: DIGIT_W]),
        .dec     (w_dec[i]),
        .q       (w_q[i]),
        .is_zero (w_dig_zero[i])
      );
    end
  endgenerate

  assign count = w_q;
  assign zero  = &w_dig_zero;
  assign tc    = en && zero;

  // Pulse once when a decrement moves the count from 1 to 0; load/clear/hold never fire it.
  always_ff @(posedge clk) begin
    if (clr) r_done <= 1'b0;
    else     r_done <= loadn && en && (count == ONE);
  end

  assign done = r_done;
endmodule

// File: tb/tb_bcd_down_timer.sv
// Scoreboard bench: mixed-radix integer model drives expectations for stop, wrap and single-digit instances.
module tb_bcd_down_timer;
  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        loadn = 1'b1;
  logic        en = 1'b0;
  logic [15:0] data = '0;

  logic [15:0] cnt_s, cnt_w;
  logic [3:0]  cnt_o;
  logic        tc_s, zero_s, done_s, tc_w, zero_w, done_w, tc_o, zero_o, done_o;

  always #5 clk = ~clk;

  bcd_down_timer #(.NDIGITS(4), .DIGIT_MAX(16'h5959), .STOP_AT_ZERO(1'b1)) u_stop (
    .clk(clk), .clr(clr), .data(data), .loadn(loadn), .en(en),
    .count(cnt_s), .tc(tc_s), .zero(zero_s), .done(done_s));

  bcd_down_timer #(.NDIGITS(4), .DIGIT_MAX(16'h5959), .STOP_AT_ZERO(1'b0)) u_wrap (
    .clk(clk), .clr(clr), .data(data), .loadn(loadn), .en(en),
    .count(cnt_w), .tc(tc_w), .zero(zero_w), .done(done_w));

  bcd_down_timer #(.NDIGITS(1), .DIGIT_MAX(4'h9), .STOP_AT_ZERO(1'b0)) u_one (
    .clk(clk), .clr(clr), .data(data[3:0]), .loadn(loadn), .en(en),
    .count(cnt_o), .tc(tc_o), .zero(zero_o), .done(done_o));

  typedef struct {
    logic [15:0] cs; bit ds;
    logic [15:0] cw; bit dw;
    logic [3:0]  co; bit d1;
    bit          e;
  } exp_t;

  exp_t q_exp[$];
  int   errs = 0;
  int   nchk = 0;
  int   m_s = 0, m_w = 0, m_o = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // Mixed-radix conversion: each digit position has radix MAX_i+1.
  function automatic int to_int(input logic [31:0] bcd, input logic [31:0] mx, input int n);
    int v = 0;
    for (int i = n - 1; i >= 0; i--) begin
      int d = int'(bcd[4*i +: 4]);
      int m = int'(mx[4*i +: 4]);
      if (d > m) d = m;
      v = v * (m + 1) + d;
    end
    return v;
  endfunction

  function automatic logic [31:0] to_bcd(input int v, input logic [31:0] mx, input int n);
    logic [31:0] r = '0;
    int t = v;
    for (int i = 0; i < n; i++) begin
      int m = int'(mx[4*i +: 4]);
      r[4*i +: 4] = 4'(t % (m + 1));
      t = t / (m + 1);
    end
    return r;
  endfunction

  task automatic model(input int cur, input int top, input bit stop, input bit c, input bit l,
                       input bit e, input int ld, output int nxt, output bit dn);
    nxt = cur; dn = 1'b0;
    if (c)       nxt = 0;
    else if (!l) nxt = ld;
    else if (e) begin
      if (cur == 0) nxt = stop ? 0 : top;
      else begin
        nxt = cur - 1;
        dn  = (cur == 1);
      end
    end
  endtask

  task automatic step(input bit c, input bit l, input bit e, input logic [15:0] d);
    exp_t x;
    int   n;
    bit   dn;
    model(m_s, to_int(32'h5959, 32'h5959, 4), 1'b1, c, l, e, to_int({16'h0, d}, 32'h5959, 4), n, dn);
    m_s = n; x.cs = to_bcd(n, 32'h5959, 4); x.ds = dn;
    model(m_w, to_int(32'h5959, 32'h5959, 4), 1'b0, c, l, e, to_int({16'h0, d}, 32'h5959, 4), n, dn);
    m_w = n; x.cw = to_bcd(n, 32'h5959, 4); x.dw = dn;
    model(m_o, 9, 1'b0, c, l, e, to_int({28'h0, d[3:0]}, 32'h9, 1), n, dn);
    m_o = n; x.co = to_bcd(n, 32'h9, 1); x.d1 = dn;
    x.e = e;
    q_exp.push_back(x);

    @(negedge clk);
    clr = c; loadn = l; en = e; data = d;
    @(posedge clk);
    #1;
    x = q_exp.pop_front();
    chk("cnt_stop",  {16'h0, cnt_s}, {16'h0, x.cs});
    chk("done_stop", {31'h0, done_s}, {31'h0, x.ds});
    chk("zero_stop", {31'h0, zero_s}, {31'h0, (x.cs == 16'h0)});
    chk("tc_stop",   {31'h0, tc_s},   {31'h0, (x.e && x.cs == 16'h0)});
    chk("cnt_wrap",  {16'h0, cnt_w}, {16'h0, x.cw});
    chk("done_wrap", {31'h0, done_w}, {31'h0, x.dw});
    chk("tc_wrap",   {31'h0, tc_w},   {31'h0, (x.e && x.cw == 16'h0)});
    chk("cnt_one",   {28'h0, cnt_o}, {28'h0, x.co});
    chk("done_one",  {31'h0, done_o}, {31'h0, x.d1});
    chk("zero_one",  {31'h0, zero_o}, {31'h0, (x.co == 4'h0)});
  endtask

  initial begin
    // reset, then clamped load
    step(1, 1, 0, 16'h0000);
    step(0, 0, 0, 16'h7A3F);
    // borrow ripple
    step(0, 0, 0, 16'h1000);
    step(0, 1, 1, 16'h0000);
    step(0, 0, 0, 16'h0100);
    step(0, 1, 1, 16'h0000);
    // reach zero, then hold (stop) / wrap
    step(0, 0, 0, 16'h0002);
    for (int k = 0; k < 5; k++) step(0, 1, 1, 16'h0000);
    // wrap from 0001
    step(0, 0, 0, 16'h0001);
    step(0, 1, 1, 16'h0000);
    step(0, 1, 1, 16'h0000);
    // en=0 hold, load still effective
    step(0, 1, 0, 16'h0000);
    step(0, 0, 0, 16'h0042);
    // priority
    step(0, 0, 1, 16'h0130);
    step(1, 0, 0, 16'h0130);
    // mid-count clear
    step(0, 0, 0, 16'h0005);
    step(0, 1, 1, 16'h0000);
    step(0, 1, 1, 16'h0000);
    step(1, 1, 1, 16'h0000);
    step(0, 1, 0, 16'h0000);
    // single-digit mod-10 sequence 3,2,1,0,9
    step(0, 0, 0, 16'h0003);
    for (int k = 0; k < 4; k++) step(0, 1, 1, 16'h0000);
    // load of zero never pulses done
    step(0, 0, 1, 16'h0000);
    step(0, 1, 0, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end
endmodule
